// File: rtl/ad_nios_adc_capture.sv
// ad_nios_adc_capture: serial ADC frame engine feeding a small
// sample FIFO, drained by the Nios CPU over an Avalon-MM slave.
module ad_nios_adc_capture #(
  parameter int DATA_WIDTH = 12,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_req,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_dout,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(SCLK_DIV);
  localparam int IW    = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  high;
  logic [DATA_WIDTH-1:0] shift;

  logic                  enable;
  logic                  irq_en;
  logic                  overflow;
  logic                  missed;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wp;
  logic [FIFO_AW-1:0]    rp;
  logic [FIFO_AW:0]      count;

  logic        cnt_end;
  logic        push;
  logic        full;
  logic        empty;
  logic        rd_req;
  logic        wr_req;
  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic        miss_set;
  logic        stat_wr;
  logic [15:0] status;
  logic [15:0] head;
  logic        unused;

  assign cnt_end  = cnt == CW'(SCLK_DIV - 1);
  assign push     = (state == SHIFT) && high &&
                    cnt_end && (idx == '0);
  assign full     = count == (FIFO_AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign rd_req   = chipselect & read;
  assign wr_req   = chipselect & write;
  assign pop      = rd_req && (address == 2'd0) && !empty;
  // a pop on the same edge frees the slot even when full
  assign push_ok  = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign miss_set = sample_req && enable && (state != IDLE);
  assign stat_wr  = wr_req && (address == 2'd1);
  assign head     = 16'(mem[rp]);
  assign status   = {overflow, missed, full, empty,
                     7'd0, 5'(count)};
  assign unused   = ^writedata[13:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      high     <= 1'b0;
      shift    <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_req && enable) begin
            state    <= SETUP;
            cnt      <= '0;
            adc_cs_n <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_end) begin
            state    <= SHIFT;
            cnt      <= '0;
            idx      <= IW'(DATA_WIDTH - 1);
            high     <= 1'b0;
            adc_sclk <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!cnt_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!high) begin
              // sample on the edge that raises sclk
              high       <= 1'b1;
              adc_sclk   <= 1'b1;
              shift[idx] <= adc_dout;
            end else if (idx == '0) begin
              state    <= HOLD;
              adc_cs_n <= 1'b1;
            end else begin
              high     <= 1'b0;
              adc_sclk <= 1'b0;
              idx      <= idx - 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      missed   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (rd_req) begin
        unique case (address)
          2'd0:    readdata <= empty ? '0 : head;
          2'd1:    readdata <= status;
          2'd2:    readdata <= {14'd0, irq_en, enable};
          default: readdata <= '0;
        endcase
      end
      if (wr_req && (address == 2'd2)) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
      end
      // a set event in the same clk beats the W1C clear
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (stat_wr && writedata[15]) begin
        overflow <= 1'b0;
      end
      if (miss_set) begin
        missed <= 1'b1;
      end else if (stat_wr && writedata[14]) begin
        missed <= 1'b0;
      end
      irq <= irq_en & (!empty | overflow);
    end
  end

endmodule

// File: tb/tb_ad_nios_adc_capture.sv
// tb_ad_nios_adc_capture: random frames and reads checked
// against a queue-based model of the FIFO and status flags.
module tb_ad_nios_adc_capture;

  localparam int DW    = 12;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int CS_LEN = (2 * DW + 1) * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_req = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_dout = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        irq;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] q[$];
  logic m_ovf = 1'b0;
  logic m_miss = 1'b0;
  logic m_en = 1'b0;
  logic m_ien = 1'b0;

  logic [DW-1:0] cur_word = '0;
  int bitk = DW - 1;
  logic irq_push;
  logic irq_next;

  always #5 clk = ~clk;

  ad_nios_adc_capture #(
    .DATA_WIDTH(DW),
    .SCLK_DIV(DIV),
    .FIFO_AW(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_req(sample_req),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_dout(adc_dout),
    .address(address),
    .chipselect(chipselect),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  // ADC presents the next bit, MSB first, on each sclk fall
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n) begin
      bitk = DW - 1;
    end else if (bitk >= 0) begin
      adc_dout = cur_word[bitk];
      bitk = bitk - 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  function automatic logic [15:0] stat_exp();
    return {m_ovf, m_miss, q.size() == DEPTH,
            q.size() == 0, 7'd0, 5'(q.size())};
  endfunction

  function automatic logic [15:0] m_pop();
    if (q.size() == 0) return 16'd0;
    return q.pop_front();
  endfunction

  function automatic void m_push(input logic [DW-1:0] w);
    if (q.size() < DEPTH) q.push_back(16'(w));
    else m_ovf = 1'b1;
  endfunction

  task automatic av_write(input logic [1:0] a,
                          input logic [15:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write = 1'b1;
    tick();
    chipselect = 1'b0;
    write = 1'b0;
    if (a == 2'd1) begin
      if (d[15]) m_ovf = 1'b0;
      if (d[14]) m_miss = 1'b0;
    end else if (a == 2'd2) begin
      m_en = d[0];
      m_ien = d[1];
    end
  endtask

  task automatic rd_check(input logic [1:0] a,
                          input string tag);
    logic [15:0] exp;
    case (a)
      2'd0: exp = m_pop();
      2'd1: exp = stat_exp();
      2'd2: exp = {14'd0, m_ien, m_en};
      default: exp = 16'd0;
    endcase
    address = a;
    chipselect = 1'b1;
    read = 1'b1;
    tick();
    chipselect = 1'b0;
    read = 1'b0;
    chk(tag, readdata, exp);
  endtask

  task automatic run_frame(input logic [DW-1:0] w,
                           input int req_at,
                           input int pop_at);
    int cyc;
    int pulses;
    int lows;
    logic prev;
    logic [15:0] popped;
    cur_word = w;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("cs_fall", adc_cs_n, 0);
    cyc = 0;
    pulses = 0;
    lows = 0;
    popped = 16'd0;
    prev = adc_sclk;
    while (!adc_cs_n && cyc < 300) begin
      if (cyc == req_at) sample_req = 1'b1;
      if (cyc == pop_at) begin
        address = 2'd0;
        chipselect = 1'b1;
        read = 1'b1;
      end
      tick();
      cyc++;
      sample_req = 1'b0;
      if (read) begin
        popped = readdata;
        chipselect = 1'b0;
        read = 1'b0;
      end
      if (!prev && adc_sclk) pulses++;
      if (!adc_sclk) lows++;
      prev = adc_sclk;
    end
    irq_push = irq;
    chk("cs_len", cyc, CS_LEN);
    chk("sclk_n", pulses, DW);
    chk("sclk_low", lows, DW * DIV);
    tick();
    irq_next = irq;
    repeat (DIV - 1) tick();
    if (req_at >= 0) m_miss = 1'b1;
    if (pop_at >= 0) chk("push_pop", popped, m_pop());
    m_push(w);
  endtask

  initial begin
    int nf;
    int nr;
    int lowc;

    repeat (3) tick();
    chk("rst_cs", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_rd", readdata, 0);
    chk("rst_irq", irq, 0);
    reset_n = 1'b1;
    tick();
    rd_check(2'd1, "rst_stat");
    rd_check(2'd2, "rst_ctrl");

    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    lowc = 0;
    repeat (8) begin
      tick();
      if (!adc_cs_n) lowc++;
    end
    chk("dis_ignore", lowc, 0);
    rd_check(2'd1, "dis_stat");

    av_write(2'd2, 16'h0001);
    rd_check(2'd2, "ctrl");
    run_frame(12'hA5C, -1, -1);
    rd_check(2'd1, "st_one");
    rd_check(2'd0, "data_a5c");
    rd_check(2'd1, "st_empty");

    for (int i = 0; i < 9; i++) begin
      run_frame(rnd(), -1, -1);
      if (i == 7) rd_check(2'd1, "st_full");
      if (i == 8) rd_check(2'd1, "st_ovf");
    end
    for (int i = 0; i < 9; i++) rd_check(2'd0, "drain9");

    run_frame(rnd(), 20, -1);
    rd_check(2'd1, "st_miss");
    av_write(2'd1, 16'h4000);
    rd_check(2'd1, "miss_clr");
    av_write(2'd1, 16'h8000);
    rd_check(2'd1, "ovf_clr");
    while (q.size() > 0) rd_check(2'd0, "drain");

    av_write(2'd0, 16'hFFFF);
    av_write(2'd3, 16'hFFFF);
    rd_check(2'd3, "addr3");
    rd_check(2'd2, "ctrl_keep");
    rd_check(2'd1, "st_keep");

    repeat (DEPTH) run_frame(rnd(), -1, -1);
    run_frame(rnd(), -1, CS_LEN - 1);
    rd_check(2'd1, "st_pushpop");
    repeat (DEPTH) rd_check(2'd0, "order");

    av_write(2'd2, 16'h0003);
    tick();
    chk("irq_idle", irq, 0);
    run_frame(rnd(), -1, -1);
    chk("irq_at_push", irq_push, 0);
    chk("irq_after", irq_next, 1);
    rd_check(2'd0, "irq_data");
    chk("irq_hold", irq, 1);
    tick();
    chk("irq_drop", irq, 0);

    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(0, 3);
      nr = $urandom_range(0, 4);
      for (int k = 0; k < nf; k++) run_frame(rnd(), -1, -1);
      for (int k = 0; k < nr; k++) rd_check(2'd0, "mix_data");
      rd_check(2'd1, "mix_stat");
      chk("mix_irq", irq,
          m_ien & ((q.size() != 0) | m_ovf));
    end

    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (40) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_cs", adc_cs_n, 1);
    chk("mid_sclk", adc_sclk, 1);
    chk("mid_irq", irq, 0);
    chk("mid_rd", readdata, 0);
    q.delete();
    m_ovf = 1'b0;
    m_miss = 1'b0;
    m_en = 1'b0;
    m_ien = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    rd_check(2'd1, "mid_stat");
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    lowc = 0;
    repeat (20) begin
      tick();
      if (!adc_cs_n) lowc++;
    end
    chk("post_ignore", lowc, 0);
    av_write(2'd2, 16'h0001);
    run_frame(rnd(), -1, -1);
    rd_check(2'd1, "post_stat");
    rd_check(2'd0, "post_data");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
